// File: rtl/answer_display_pkg.sv
//------------------------------------------------------------------------------
// Module   : answer_display_pkg
// Brief    : Seven-segment types, constants and hex-to-segment encoder shared
//            by the answer display path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package answer_display_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam seg_t SEG_ZERO  = 7'b1000000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_edge_sync.sv
//------------------------------------------------------------------------------
// Module   : button_edge_sync
// Brief    : 2-FF synchroniser followed by a rising-edge detector; one pulse
//            per press regardless of hold time.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_pulse
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       edge_q,  edge_d;
    logic [1:0] settle_q, settle_d;

    // The edge detector stays disarmed until the chain holds post-reset samples,
    // so a button held through reset never looks like a fresh press.
    always_comb begin
        sync1_d  = i_raw;
        sync2_d  = sync1_q;
        edge_d   = sync2_q;
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            edge_q   <= edge_d;
            settle_q <= settle_d;
        end
    end

    assign o_pulse = sync2_q & ~edge_q & (settle_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/answer_window_scroller.sv
//------------------------------------------------------------------------------
// Module   : answer_window_scroller
// Brief    : Captures an answer and drives a scrollable WIN_DIGITS-wide
//            seven-segment window plus a one-hot position LED bar.
//            Optional macro AUTO_SCROLL_EN adds a wrapping auto-scroll timer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module answer_window_scroller
    import answer_display_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int WIN_DIGITS = 4,
    parameter  int SCROLL_DIV = 50000000,
    localparam int NUM_DIGITS = DATA_W / 4,
    localparam int MAX_OFF    = NUM_DIGITS - WIN_DIGITS,
    localparam int OFF_W      = (MAX_OFF > 0) ? $clog2(MAX_OFF + 1) : 1
) (
    input  logic                      IN_clk,
    input  logic                      IN_reset,
    input  logic [DATA_W-1:0]         IN_binary_answer,
    input  logic                      IN_answer_valid,
    input  logic                      IN_up_button,
    input  logic                      IN_down_button,
    input  logic                      IN_center_button,
    input  logic                      IN_auto,
    output logic [SEG_W*WIN_DIGITS-1:0] OUT_digits,
    output logic [OFF_W-1:0]          OUT_offset,
    output logic [MAX_OFF:0]          OUT_led
);

    localparam logic [OFF_W-1:0] MAX_OFF_V = OFF_W'(MAX_OFF);

    logic center_ev, up_ev, down_ev;
    logic btn_any, auto_step;

    logic [DATA_W-1:0]           ans_q, ans_d;
    logic [DATA_W-1:0]           shifted;
    logic [OFF_W-1:0]            offset_q, offset_d;
    logic [OFF_W-1:0]            out_off_q, out_off_d;
    seg_t [WIN_DIGITS-1:0]       digits_q, digits_d;
    logic [MAX_OFF:0]            led_q, led_d;

    button_edge_sync u_center_sync (
        .clk(IN_clk), .rst(IN_reset), .i_raw(IN_center_button), .o_pulse(center_ev)
    );
    button_edge_sync u_up_sync (
        .clk(IN_clk), .rst(IN_reset), .i_raw(IN_up_button), .o_pulse(up_ev)
    );
    button_edge_sync u_down_sync (
        .clk(IN_clk), .rst(IN_reset), .i_raw(IN_down_button), .o_pulse(down_ev)
    );

    assign btn_any = (MAX_OFF > 0) && (center_ev || up_ev || down_ev);

`ifdef AUTO_SCROLL_EN
    localparam int TIMER_W = $clog2(SCROLL_DIV);

    logic [TIMER_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d   = timer_q;
        auto_step = 1'b0;
        if (!IN_auto || btn_any) begin
            timer_d = '0;
        end else if (timer_q == TIMER_W'(SCROLL_DIV - 1)) begin
            timer_d   = '0;
            auto_step = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) timer_q <= '0;
        else          timer_q <= timer_d;
    end
`else
    logic unused_auto;
    assign unused_auto = IN_auto;
    assign auto_step   = 1'b0;
`endif

    always_comb begin
        offset_d = offset_q;
        if (MAX_OFF > 0) begin
            if (center_ev) begin
                offset_d = '0;
            end else if (up_ev && !down_ev) begin
                if (offset_q != MAX_OFF_V) offset_d = offset_q + 1'b1;
            end else if (down_ev && !up_ev) begin
                if (offset_q != '0) offset_d = offset_q - 1'b1;
            end else if (auto_step) begin
                offset_d = (offset_q == MAX_OFF_V) ? '0 : offset_q + 1'b1;
            end
        end
    end

    // Display uses the incoming answer so a capture shows up one clock later.
    always_comb begin
        ans_d   = IN_answer_valid ? IN_binary_answer : ans_q;
        shifted = ans_d >> {offset_q, 2'b00};
        for (int i = 0; i < WIN_DIGITS; i++) begin
            digits_d[i] = hex_to_seg(shifted[4*i +: 4]);
        end
        led_d           = '0;
        led_d[offset_q] = 1'b1;
        out_off_d       = offset_q;
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            ans_q     <= '0;
            offset_q  <= '0;
            out_off_q <= '0;
            digits_q  <= {WIN_DIGITS{SEG_ZERO}};
            led_q     <= (MAX_OFF + 1)'(1);
        end else begin
            ans_q     <= ans_d;
            offset_q  <= offset_d;
            out_off_q <= out_off_d;
            digits_q  <= digits_d;
            led_q     <= led_d;
        end
    end

    assign OUT_digits = digits_q;
    assign OUT_offset = out_off_q;
    assign OUT_led    = led_q;

endmodule

`default_nettype wire

// File: tb/tb_answer_window_scroller.sv
//------------------------------------------------------------------------------
// Module   : tb_answer_window_scroller
// Brief    : Directed plus randomized bench for answer_window_scroller with a
//            cycle-level reference model. Honours AUTO_SCROLL_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_answer_window_scroller;

    localparam int DATA_W  = 32;
    localparam int WIN     = 4;
    localparam int DIV     = 4;
    localparam int NUM     = DATA_W / 4;
    localparam int MAX_OFF = NUM - WIN;
    localparam int OFF_W   = (MAX_OFF > 0) ? $clog2(MAX_OFF + 1) : 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, valid, up, down, center, auto_en;
    logic [DATA_W-1:0] bin;
    logic [7*WIN-1:0]  dig;
    logic [OFF_W-1:0]  off;
    logic [MAX_OFF:0]  led;

    answer_window_scroller #(
        .DATA_W(DATA_W), .WIN_DIGITS(WIN), .SCROLL_DIV(DIV)
    ) dut (
        .IN_clk(clk), .IN_reset(rst), .IN_binary_answer(bin), .IN_answer_valid(valid),
        .IN_up_button(up), .IN_down_button(down), .IN_center_button(center),
        .IN_auto(auto_en), .OUT_digits(dig), .OUT_offset(off), .OUT_led(led)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: answer, offset, auto timer and post-reset button samples.
    logic [DATA_W-1:0] ans_m;
    int                off_m, t_m;
    bit                hu[$], hd[$], hc[$];
    logic [7*WIN-1:0]  e_dig;
    int                e_off;
    logic [MAX_OFF:0]  e_led;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[h];
    endfunction

    function automatic logic [7*WIN-1:0] ref_window(input logic [DATA_W-1:0] a, input int o);
        logic [7*WIN-1:0] r;
        for (int i = 0; i < WIN; i++) r[7*i +: 7] = ref_seg(a[4*(o+i) +: 4]);
        return r;
    endfunction

    // A press registers when the sample two edges back is high and the one
    // before it is low, counting only samples taken since reset released.
    function automatic bit rise(input bit h[$]);
        if (h.size() < 3) return 1'b0;
        return h[h.size()-2] && !h[h.size()-3];
    endfunction

    task automatic model_step();
        bit ev_c, ev_u, ev_d, any;
        if (rst) begin
            ans_m = '0; off_m = 0; t_m = 0;
            hu.delete(); hd.delete(); hc.delete();
            e_dig = {WIN{7'b1000000}};
            e_off = 0;
            e_led = '0; e_led[0] = 1'b1;
        end else begin
            ev_c = rise(hc); ev_u = rise(hu); ev_d = rise(hd);
            hc.push_back(center); hu.push_back(up); hd.push_back(down);
            if (hc.size() > 4) begin void'(hc.pop_front()); void'(hu.pop_front()); void'(hd.pop_front()); end
            if (valid) ans_m = bin;
            e_dig = ref_window(ans_m, off_m);
            e_off = off_m;
            e_led = '0; e_led[off_m] = 1'b1;
            any = (MAX_OFF > 0) && (ev_c || ev_u || ev_d);
            if (MAX_OFF > 0) begin
                if (ev_c)             off_m = 0;
                else if (ev_u && !ev_d) off_m = (off_m < MAX_OFF) ? off_m + 1 : MAX_OFF;
                else if (ev_d && !ev_u) off_m = (off_m > 0) ? off_m - 1 : 0;
            end
`ifdef AUTO_SCROLL_EN
            if (!auto_en || any) t_m = 0;
            else if (t_m == DIV - 1) begin
                t_m = 0;
                off_m = (off_m == MAX_OFF) ? 0 : off_m + 1;
            end else t_m++;
`else
            if (any) t_m = 0;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("digits", dig, e_dig);
        check_val("offset", off, e_off);
        check_val("led", led, e_led);
    endtask

    task automatic press(input int which, input int hold, input int gap);
        if (which == 0) up = 1'b1; else if (which == 1) down = 1'b1; else center = 1'b1;
        repeat (hold) tick();
        up = 1'b0; down = 1'b0; center = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; up = 1'b0; down = 1'b0; center = 1'b0;
        auto_en = 1'b0; bin = '0;
        repeat (3) tick();
        check_val("rst_digits", dig, {4{7'b1000000}});
        check_val("rst_led", led, 5'b00001);
        check_val("rst_offset", off, 0);
        rst = 1'b0;
        repeat (4) tick();

        bin = 32'h89AB_CDEF; valid = 1'b1;
        tick();
        valid = 1'b0;
        check_val("capture_win0", dig, {7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110});

        repeat (5) press(0, 20, 10);
        check_val("up_sat_offset", off, 4);
        check_val("up_sat_led", led, 5'b10000);
        check_val("up_sat_digits", dig, {7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011});

        press(1, 10, 10);
        check_val("down_to_3", off, 3);
        up = 1'b1; center = 1'b1;
        repeat (10) tick();
        up = 1'b0; center = 1'b0;
        repeat (10) tick();
        check_val("center_beats_up", off, 0);
        press(0, 10, 10);
        up = 1'b1; down = 1'b1;
        repeat (10) tick();
        up = 1'b0; down = 1'b0;
        repeat (10) tick();
        check_val("up_down_cancel", off, 1);
        press(2, 10, 10);
        press(1, 10, 10);
        check_val("down_floor", off, 0);

        press(0, 10, 10);
        up = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (12) tick();
        check_val("held_reset_offset", off, 0);
        check_val("held_reset_digits", dig, {4{7'b1000000}});
        up = 1'b0;
        repeat (5) tick();

`ifdef AUTO_SCROLL_EN
        bin = 32'h0123_4567; valid = 1'b1; tick(); valid = 1'b0;
        auto_en = 1'b1;
        repeat (22) tick();
        press(0, 6, 20);
        auto_en = 1'b0;
        repeat (5) tick();
`endif

        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            valid = ($urandom_range(0, 7) == 0);
            bin   = $urandom;
            if ($urandom_range(0, 5) == 0)  up      = ~up;
            if ($urandom_range(0, 5) == 0)  down    = ~down;
            if ($urandom_range(0, 11) == 0) center  = ~center;
            if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
